comparator_bist: RTL and testbench

Self-checking built-in test sequencer for the comparator family (`comparator_1bit` and wider variants). It drives every A/B operand combination into a comparator under test, samples its less/greater/equal outputs after a programmable settle time, and scores each result against the expected relation. It sits beside the comparator as the response-checking end of its interface. It reports pass/fail, an error count and the first failing vector.

---
 rtl/comparator_bist.sv | 119 +++++++++++
 tb/tb_comparator_bist.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_bist.sv
// Built-in test sequencer for the comparator family: sweeps every A/B pair, scores l/g/e.
// Optional macro COMPARATOR_BIST_EARLY_ABORT_EN ends the run on the first mismatch.
module comparator_bist #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic             l,
    input  logic             g,
    input  logic             e,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam int unsigned VW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [VW-1:0]    r_vec;
    logic [7:0]       r_settle;
    logic [15:0]      r_err_count;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;
    logic             r_pass;
    logic             w_mismatch;
    logic             w_last;

    assign a         = r_vec[VW-1:WIDTH];
    assign b         = r_vec[WIDTH-1:0];
    assign busy      = (r_state == S_WAIT) || (r_state == S_CHECK);
    assign done      = (r_state == S_DONE);
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_a    = r_fail_a;
    assign fail_b    = r_fail_b;

    // Any differing flag counts as a single mismatch for the vector.
    assign w_mismatch = (l != (a < b)) || (g != (a > b)) || (e != (a == b));
    assign w_last     = &r_vec;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_WAIT;
            S_WAIT:  if (r_settle == 8'd0) w_state_nxt = S_CHECK;
            S_CHECK: begin
`ifdef COMPARATOR_BIST_EARLY_ABORT_EN
                if (w_last || w_mismatch) w_state_nxt = S_DONE;
`else
                if (w_last) w_state_nxt = S_DONE;
`endif
                else w_state_nxt = S_WAIT;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_vec       <= '0;
            r_settle    <= '0;
            r_err_count <= '0;
            r_fail_a    <= '0;
            r_fail_b    <= '0;
            r_pass      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec       <= '0;
                        r_settle    <= 8'(SETTLE - 1);
                        r_err_count <= '0;
                        r_fail_a    <= '0;
                        r_fail_b    <= '0;
                        r_pass      <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (r_settle != 8'd0) r_settle <= r_settle - 8'd1;
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_count != '1) r_err_count <= r_err_count + 16'd1;
                        if (r_err_count == '0) begin
                            r_fail_a <= a;
                            r_fail_b <= b;
                        end
                    end
                    if (w_state_nxt == S_WAIT) begin
                        r_vec    <= r_vec + VW'(1);
                        r_settle <= 8'(SETTLE - 1);
                    end
                    // Pass is resolved on entry to DONE, folding in this cycle's result.
                    if (w_state_nxt == S_DONE) r_pass <= (r_err_count == '0) && !w_mismatch;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: three instances (W1/S1, W2/S3, W7/S1) driving faulty comparator models.
module tb_comparator_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_r = 1'b0;
    int   sel = 1;
    int   mode = 0;
    int   checks = 0;
    int   failures = 0;

    logic       st1, st2, st7;
    logic [0:0] a1, b1, fa1, fb1;
    logic [1:0] a2, b2, fa2, fb2;
    logic [6:0] a7, b7, fa7, fb7;
    logic       l1, g1, e1, l2, g2, e2, l7, g7, e7;
    logic       busy1, done1, pass1, busy2, done2, pass2, busy7, done7, pass7;
    logic [15:0] err1, err2, err7;

    int   obs_a, obs_b, obs_err, obs_fa, obs_fb;
    logic obs_busy, obs_done, obs_pass;

    int   m_lat, m_err, m_fa, m_fb;
    bit   m_seq_ok, m_done_seen, m_single, m_busy_at_done, m_pass_at_done;

    always #5 clk = ~clk;

    assign st1 = start_r && (sel == 1);
    assign st2 = start_r && (sel == 2);
    assign st7 = start_r && (sel == 3);

    comparator_bist #(.WIDTH(1), .SETTLE(1)) d1 (
        .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .l(l1), .g(g1), .e(e1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_a(fa1), .fail_b(fb1));
    comparator_bist #(.WIDTH(2), .SETTLE(3)) d2 (
        .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .l(l2), .g(g2), .e(e2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_a(fa2), .fail_b(fb2));
    comparator_bist #(.WIDTH(7), .SETTLE(1)) d7 (
        .clk(clk), .rst(rst), .start(st7), .a(a7), .b(b7), .l(l7), .g(g7), .e(e7),
        .busy(busy7), .done(done7), .pass(pass7), .err_count(err7), .fail_a(fa7), .fail_b(fb7));

    // Comparator under test: 0 correct, 1 g stuck 0, 2 l/g swapped, 3 e stuck 1.
    function automatic logic [2:0] cmp_model(int m, int x, int y);
        logic lt = (x < y);
        logic gt = (x > y);
        logic eq = (x == y);
        logic t;
        case (m)
            1: gt = 1'b0;
            2: begin t = lt; lt = gt; gt = t; end
            3: eq = 1'b1;
            default: ;
        endcase
        return {lt, gt, eq};
    endfunction

    always_comb begin
        {l1, g1, e1} = cmp_model(mode, int'(a1), int'(b1));
        {l2, g2, e2} = cmp_model(mode, int'(a2), int'(b2));
        {l7, g7, e7} = cmp_model(mode, int'(a7), int'(b7));
    end

    always_comb begin
        obs_a = 0; obs_b = 0; obs_err = 0; obs_fa = 0; obs_fb = 0;
        obs_busy = 1'b0; obs_done = 1'b0; obs_pass = 1'b0;
        case (sel)
            1: begin
                obs_a = int'(a1); obs_b = int'(b1); obs_err = int'(err1); obs_fa = int'(fa1);
                obs_fb = int'(fb1); obs_busy = busy1; obs_done = done1; obs_pass = pass1;
            end
            2: begin
                obs_a = int'(a2); obs_b = int'(b2); obs_err = int'(err2); obs_fa = int'(fa2);
                obs_fb = int'(fb2); obs_busy = busy2; obs_done = done2; obs_pass = pass2;
            end
            default: begin
                obs_a = int'(a7); obs_b = int'(b7); obs_err = int'(err7); obs_fa = int'(fa7);
                obs_fb = int'(fb7); obs_busy = busy7; obs_done = done7; obs_pass = pass7;
            end
        endcase
    end

    function automatic int sel_w(int s);
        return (s == 1) ? 1 : (s == 2) ? 2 : 7;
    endfunction

    function automatic int sel_s(int s);
        return (s == 2) ? 3 : 1;
    endfunction

    // Expected run outcome from the sweep rules: ordered pairs, SETTLE+1 cycles each.
    function automatic void ref_run(int w, int s, int m, output int errs, output int fa,
                                    output int fb, output int len);
        errs = 0; fa = 0; fb = 0; len = 0;
        for (int v = 0; v < (1 << (2 * w)); v++) begin
            int x = v >> w;
            int y = v & ((1 << w) - 1);
            len += s + 1;
            if (cmp_model(m, x, y) != {x < y, x > y, x == y}) begin
                if (errs == 0) begin fa = x; fb = y; end
                errs++;
`ifdef COMPARATOR_BIST_EARLY_ABORT_EN
                break;
`endif
            end
        end
        if (errs > 65535) errs = 65535;
    endfunction

    // Starts a run on the selected instance and records what it observes.
    task automatic run_measure(input int pulse_at, input int rst_at);
        int w = sel_w(sel);
        int s = sel_s(sel);
        int limit = (1 << (2 * w)) * (s + 1) + 4;
        m_lat = -1; m_seq_ok = 1; m_done_seen = 0; m_single = 0;
        m_busy_at_done = 1; m_pass_at_done = 0; m_err = 0; m_fa = 0; m_fb = 0;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        #1 start_r = 1'b0;
        for (int j = 0; j < limit; j++) begin
            if (obs_done) begin
                m_done_seen = 1; m_lat = j; m_busy_at_done = obs_busy; m_pass_at_done = obs_pass;
                m_err = obs_err; m_fa = obs_fa; m_fb = obs_fb;
                @(posedge clk);
                #1 m_single = !obs_done;
                return;
            end
            if (!obs_busy || obs_a != ((j / (s + 1)) >> w) ||
                obs_b != ((j / (s + 1)) & ((1 << w) - 1))) m_seq_ok = 0;
            if (j == pulse_at) start_r = 1'b1;
            if (j == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                start_r = 1'b0;
                return;
            end
            @(posedge clk);
            #1 start_r = 1'b0;
        end
    endtask

    task automatic check_run(input string name, input int pulse_at);
        int e_err, e_fa, e_fb, e_len;
        ref_run(sel_w(sel), sel_s(sel), mode, e_err, e_fa, e_fb, e_len);
        run_measure(pulse_at, -1);
        checks++;
        if (m_lat !== e_len) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, m_lat, e_len);
        end
        checks++;
        if ({m_err, m_fa, m_fb} !== {e_err, e_fa, e_fb}) begin
            failures++;
            $display("FAIL %s result: err=%0d fail_a=%0d fail_b=%0d expected err=%0d fail_a=%0d fail_b=%0d",
                     name, m_err, m_fa, m_fb, e_err, e_fa, e_fb);
        end
        checks++;
        if ({m_pass_at_done, m_busy_at_done, m_single, m_seq_ok} !== {(e_err == 0), 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL %s flags: pass=%0b busy=%0b single_done=%0b seq_ok=%0b expected pass=%0b busy=0 single_done=1 seq_ok=1",
                     name, m_pass_at_done, m_busy_at_done, m_single, m_seq_ok, (e_err == 0));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            sel = s;
            #1;
            checks++;
            if ({obs_a, obs_b, obs_err, obs_fa, obs_fb, obs_busy, obs_done, obs_pass} !== '0) begin
                failures++;
                $display("FAIL reset[%0d]: a=%0d b=%0d err=%0d fa=%0d fb=%0d busy=%0b done=%0b pass=%0b expected all 0",
                         s, obs_a, obs_b, obs_err, obs_fa, obs_fb, obs_busy, obs_done, obs_pass);
            end
        end
    endtask

    task automatic test_correct();
        sel = 1; mode = 0;
        check_run("w1_correct", -1);
    endtask

    task automatic test_g_stuck();
        sel = 1; mode = 1;
        check_run("w1_g_stuck", -1);
    endtask

    task automatic test_swap_w2();
        sel = 2; mode = 2;
        check_run("w2_swap", -1);
    endtask

    task automatic test_back_to_back();
        sel = 1; mode = 1;
        check_run("w1_restart_ignored", 3);
        sel = 2; mode = 3;
        check_run("w2_restart_ignored", 10);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            sel = int'($urandom_range(1, 2));
            mode = int'($urandom_range(0, 3));
            check_run($sformatf("rand%0d_s%0d_m%0d", i, sel, mode), int'($urandom_range(1, 6)));
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done = 0;
        sel = 1; mode = 0;
        run_measure(-1, 4);
        checks++;
        if ({obs_a, obs_b, obs_err, obs_fa, obs_fb, obs_busy, obs_done, obs_pass} !== '0) begin
            failures++;
            $display("FAIL abort_reset_values: a=%0d b=%0d err=%0d busy=%0b done=%0b pass=%0b expected all 0",
                     obs_a, obs_b, obs_err, obs_busy, obs_done, obs_pass);
        end
        repeat (12) begin
            @(posedge clk);
            #1 if (obs_done) saw_done = 1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: done seen=%0b expected 0", saw_done);
        end
        check_run("after_abort", -1);
    endtask

    task automatic test_w7_count();
        sel = 3; mode = 3;
        check_run("w7_e_stuck", -1);
    endtask

    task automatic test_saturation();
        sel = 3; mode = 3;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        #1 start_r = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        force d7.r_err_count = 16'hFFFE;
        #1 release d7.r_err_count;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (obs_err !== 65535) begin
            failures++;
            $display("FAIL saturation: err_count=%0h expected ffff", obs_err);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_correct();
        test_g_stuck();
        test_swap_w2();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_w7_count();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
